// File: rtl/color_pkg.sv
// Shared colour codes, filter states and the raw-line classifier.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
package color_pkg;

  // Committed/candidate colour code; also consumed by the downstream colour FSM
  typedef enum logic [2:0] {
    CODE_NONE     = 3'd0,
    CODE_RED      = 3'd1,
    CODE_GREEN    = 3'd2,
    CODE_BLUE     = 3'd3,
    CODE_CONFLICT = 3'd4
  } colorCode_t;

  // Filter qualification state
  typedef enum logic {
    STATE_WAIT = 1'b0,
    STATE_QUAL = 1'b1
  } filterState_t;

  // Map three synchronised sensor bits onto a single colour code
  function automatic colorCode_t classifyColor(input logic red, input logic green, input logic blue);
    colorCode_t code;
    case ({red, green, blue})
      3'b000:  code = CODE_NONE;
      3'b100:  code = CODE_RED;
      3'b010:  code = CODE_GREEN;
      3'b001:  code = CODE_BLUE;
      default: code = CODE_CONFLICT;
    endcase
    return code;
  endfunction

endpackage

// File: rtl/color_sync2.sv
// Two-flop synchroniser for one asynchronous sensor line.
// Latency: 2 Clock edges from Raw to Sync.
// Backpressure: none; samples every cycle.
module color_sync2 (
  input  logic Clock,
  input  logic Reset,
  input  logic Raw,
  output logic Sync
);

  logic meta;

  // Shift the raw line through two flops to settle metastability
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      meta <= 1'b0;
      Sync <= 1'b0;
    end else begin
      meta <= Raw;
      Sync <= meta;
    end
  end

endmodule

// File: rtl/color_input_filter.sv
// Debounces three raw colour-sensor lines into one committed, mutually exclusive colour.
// Latency: 2 + STABLE_CYCLES edges from a stable raw pattern to the outputs.
// Backpressure: none; free-running sampler, downstream must accept every Change pulse.
module color_input_filter
  import color_pkg::*;
#(
  parameter int STABLE_CYCLES = 4,  // consecutive equal samples to commit, 2..255
  parameter int CNT_W         = 8   // must be wide enough to hold STABLE_CYCLES-1
) (
  input  logic Clock,
  input  logic Reset,
  input  logic RedRaw,
  input  logic GreenRaw,
  input  logic BlueRaw,
  output logic Red,
  output logic Green,
  output logic Blue,
  output logic Conflict,
  output logic Change
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);

  logic         redSync;
  logic         greenSync;
  logic         blueSync;
  colorCode_t   sample;
  colorCode_t   committed;
  colorCode_t   candidate;
  logic [CNT_W-1:0] cnt;
  filterState_t state;

  color_sync2 u_redSync   (.Clock(Clock), .Reset(Reset), .Raw(RedRaw),   .Sync(redSync));
  color_sync2 u_greenSync (.Clock(Clock), .Reset(Reset), .Raw(GreenRaw), .Sync(greenSync));
  color_sync2 u_blueSync  (.Clock(Clock), .Reset(Reset), .Raw(BlueRaw),  .Sync(blueSync));

  // Classify the synchronised bits into this cycle's sample code
  always_comb begin
    sample = classifyColor(redSync, greenSync, blueSync);
  end

  // Qualification FSM; the colour flags are reloaded only at commit so they
  // switch in a single edge and never show two colours or a gap between them
  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      state     <= STATE_WAIT;
      committed <= CODE_NONE;
      candidate <= CODE_NONE;
      cnt       <= '0;
      Red       <= 1'b0;
      Green     <= 1'b0;
      Blue      <= 1'b0;
      Conflict  <= 1'b0;
      Change    <= 1'b0;
    end else begin
      Change <= 1'b0;
      case (state)
        STATE_WAIT: begin
          if (sample == committed) begin
            cnt <= '0;
          end else begin
            candidate <= sample;
            cnt       <= CNT_W'(1);
            state     <= STATE_QUAL;
          end
        end
        STATE_QUAL: begin
          if (sample == candidate) begin
            // Saturating compare keeps the counter from ever passing CNT_MAX
            if (cnt >= CNT_MAX) begin
              committed <= candidate;
              Red       <= (candidate == CODE_RED);
              Green     <= (candidate == CODE_GREEN);
              Blue      <= (candidate == CODE_BLUE);
              Conflict  <= (candidate == CODE_CONFLICT);
              Change    <= 1'b1;
              cnt       <= '0;
              state     <= STATE_WAIT;
            end else begin
              cnt <= cnt + CNT_W'(1);
            end
          end else if (sample == committed) begin
            // Input fell back to the committed colour: drop the candidate silently
            cnt   <= '0;
            state <= STATE_WAIT;
          end else begin
            // A different new colour appeared: restart qualification on it
            candidate <= sample;
            cnt       <= CNT_W'(1);
          end
        end
        default: begin
          cnt   <= '0;
          state <= STATE_WAIT;
        end
      endcase
    end
  end

endmodule
